seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 250: clocks per digit slot; SHALL satisfy SCAN_DIV > BLANK_CYC.
REQ-002 Parameter BLANK_CYC, default 8: clocks of the anti-ghost blank at the start of each slot; SHALL be >= 1.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 wr_valid  input  1  new 4-digit BCD value offered.
REQ-006 wr_ready  output  1  pending buffer empty; write accepted when wr_valid && wr_ready.
REQ-007 wr_data  input  16  digits: digit0 = [3:0] (least significant) ... digit3 = [15:12].
REQ-008 lz_blank  input  1  leading-zero blanking enable.
REQ-009 bright  input  3  brightness, 0 = dimmest, 7 = full.
REQ-010 seg  output  7  segments, active-high, bit0 = a ... bit6 = g.
REQ-011 dig_en  output  4  one-hot digit enable, active-high, bit i = digit i.
REQ-012 frame_done  output  1  single-cycle pulse at end of each 4-digit frame.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states BLANK and SHOW; slot = BLANK for BLANK_CYC cycles, then SHOW for SHOW_CYC = SCAN_DIV - BLANK_CYC cycles.
REQ-015 On leaving SHOW, digit index SHALL increment 0->1->2->3->0 and the FSM SHALL enter BLANK.
REQ-016 In BLANK: seg = 0, dig_en = 0.
REQ-017 In SHOW: seg = decode(active digit[index]); dig_en = one-hot(index) gated by PWM (REQ-019).
REQ-018 Decode 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); values 10-15 SHALL give seg = 0.
REQ-019 PWM: with s = SHOW-cycle count 0..SHOW_CYC-1, dig_en asserted only when (s mod 8) <= bright_q; bright_q SHALL be bright sampled on the first SHOW cycle of each slot.
REQ-020 Leading-zero blanking: when lz_blank = 1, digit i (i = 3,2,1) SHALL show seg = 0 if it and all higher digits are 0; digit0 is never blanked; dig_en is unaffected.
REQ-021 Double buffering: an accepted write SHALL load the pending buffer and set pending-full; wr_ready = !pending-full.
REQ-022 Swap: on the edge leaving SHOW of digit 3, if pending-full, the active register SHALL load the pending buffer and pending-full SHALL clear (wr_ready high the following cycle).
REQ-023 frame_done SHALL be high for exactly one cycle, the first BLANK cycle of digit 0 following each swap point, whether or not a swap occurred.
REQ-024 Write and swap on the same edge: impossible when pending-full (wr_ready = 0); when pending empty, the write SHALL fill pending and be displayed from the next frame.
REQ-025 Displayed digits SHALL change only at frame boundaries; the active register is never written mid-frame.
REQ-026 Timer width SHALL be clog2(SCAN_DIV); the counter SHALL wrap only at the slot boundary, never overflow.

Reset
REQ-027 While reset is high: state = BLANK, index = 0, timer = 0, active = 0x0000, pending-full = 0, bright_q = 7, seg = 0, dig_en = 0, wr_ready = 1, frame_done = 0.
REQ-028 Reset asserted mid-operation SHALL take effect on the next edge, discarding pending data; the first post-reset slot SHALL be digit 0 starting with a full BLANK.

Verification (SCAN_DIV = 16, BLANK_CYC = 4, SHOW_CYC = 12)
REQ-029 Reset, release, bright = 7 -> 4 cycles with dig_en = 0, then 12 cycles with dig_en = 0001 and seg = 3F; wr_ready = 1 throughout.
REQ-030 Write 0x1234 -> from the first frame after frame_done: digit0 seg = 66, digit1 = 4F, digit2 = 5B, digit3 = 06.
REQ-031 Write 0x1234, then hold wr_valid with 0x5678 -> wr_ready = 0 until the swap, second write accepted the cycle after; 0x1234 is shown for one full frame, then 0x5678; no data lost.
REQ-032 lz_blank = 1, data 0x0050 -> digits 3 and 2 seg = 0 with dig_en still pulsing, digit1 = 6D, digit0 = 3F; data 0x0000 -> only digit0 lit (3F); data 0x00A0 -> digit1 seg = 0.
REQ-033 bright = 1 -> per SHOW, dig_en high on s = 0,1,8,9 only (4 of 12 cycles); bright changed mid-SHOW -> no effect until next slot.
REQ-034 Reset pulsed during SHOW of digit 2 with pending full -> next cycle all REQ-027 values; pending contents never displayed.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with anti-ghost blanking, PWM dimming,
// leading-zero suppression and a double-buffered write port swapped at frame boundaries.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 250,
  parameter int BLANK_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic        lz_blank,
  input  logic [2:0]  bright,
  output logic [6:0]  seg,
  output logic [3:0]  dig_en,
  output logic        frame_done
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] SHOW_FIRST = TW'(BLANK_CYC);
  localparam logic [TW-1:0] SLOT_LAST  = TW'(SCAN_DIV - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [1:0]      index_reg, index_next;
  logic [2:0]      phase_reg, phase_next;
  logic [2:0]      bright_q_reg;
  logic [15:0]     active_reg;
  logic [15:0]     pending_reg;
  logic            pending_full_reg, pending_full_next;
  logic            wr_ready_reg;
  logic [6:0]      seg_reg, seg_next;
  logic [3:0]      dig_en_reg, dig_en_next;
  logic            frame_done_reg;

  logic            frame_end;
  logic            wr_fire;
  logic            swap;
  logic            sample_now;
  logic [2:0]      bright_eff;
  logic            pwm_on;
  logic [6:0]      shown_seg;
  logic [3:0]      digit [4];
  logic [3:0]      lz_kill;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digit[gi] = active_reg[4*gi +: 4];
    end
  endgenerate

  // A digit is suppressed when it and every more significant digit are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_kill    = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      zero_above = zero_above && (digit[i] == 4'd0);
      lz_kill[i] = lz_blank && zero_above && (i != 0);
    end
  end

  // Slot sequencing: timer runs 0..SCAN_DIV-1 across one digit slot.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + TW'(1);
    index_next = index_reg;
    frame_end  = 1'b0;
    case (state_reg)
      BLANK: begin
        if (timer_reg == BLANK_LAST) state_next = SHOW;
      end
      SHOW: begin
        if (timer_reg == SLOT_LAST) begin
          state_next = BLANK;
          timer_next = '0;
          index_next = index_reg + 2'd1;
          frame_end  = (index_reg == 2'd3);
        end
      end
      default: begin
        state_next = BLANK;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are computed for the upcoming cycle so the registers line up with state.
  // Brightness is latched during s=0; that cycle is lit for any brightness, so the
  // value seen then can steer the rest of the slot.
  always_comb begin
    phase_next  = (state_next == SHOW && state_reg == SHOW) ? phase_reg + 3'd1 : 3'd0;
    sample_now  = (state_reg == SHOW) && (timer_reg == SHOW_FIRST);
    bright_eff  = sample_now ? bright : bright_q_reg;
    pwm_on      = (phase_next <= bright_eff);
    shown_seg   = lz_kill[index_reg] ? 7'h00 : decode(digit[index_reg]);
    seg_next    = (state_next == SHOW) ? shown_seg : 7'h00;
    dig_en_next = (state_next == SHOW && pwm_on) ? (4'b0001 << index_reg) : 4'b0000;
  end

  // Write and swap cannot coincide: writes need an empty buffer, swaps a full one.
  always_comb begin
    wr_fire           = wr_valid && !pending_full_reg;
    swap              = frame_end && pending_full_reg;
    pending_full_next = pending_full_reg;
    if (swap)
      pending_full_next = 1'b0;
    else if (wr_fire)
      pending_full_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= BLANK;
      timer_reg        <= '0;
      index_reg        <= 2'd0;
      phase_reg        <= 3'd0;
      bright_q_reg     <= 3'd7;
      active_reg       <= 16'h0000;
      pending_reg      <= 16'h0000;
      pending_full_reg <= 1'b0;
      wr_ready_reg     <= 1'b1;
      seg_reg          <= 7'h00;
      dig_en_reg       <= 4'b0000;
      frame_done_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      timer_reg        <= timer_next;
      index_reg        <= index_next;
      phase_reg        <= phase_next;
      if (sample_now) bright_q_reg <= bright;
      if (wr_fire) pending_reg <= wr_data;
      if (swap) active_reg <= pending_reg;
      pending_full_reg <= pending_full_next;
      wr_ready_reg     <= !pending_full_next;
      seg_reg          <= seg_next;
      dig_en_reg       <= dig_en_next;
      frame_done_reg   <= frame_end;
    end
  end

  assign wr_ready   = wr_ready_reg;
  assign seg        = seg_reg;
  assign dig_en     = dig_en_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (SCAN_DIV=16, BLANK_CYC=4): expected frames are
// queued as stimulus is applied and compared against whole captured frames.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int SD = 16;
  localparam int BC = 4;
  localparam int SC = SD - BC;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = 16'h0000;
  logic        lz_blank = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .lz_blank(lz_blank), .bright(bright), .seg(seg),
    .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [6:0] seg; logic [3:0] dig_en; } cyc_exp_t;
  typedef struct packed { logic [27:0] segs; logic [47:0] masks; logic [2:0] fd; } frame_exp_t;

  cyc_exp_t   cyc_q[$];
  frame_exp_t frame_q[$];

  int vec = 0;
  int err = 0;

  logic [6:0]  obs_seg  [4];
  logic [11:0] obs_mask [4];
  logic [2:0]  obs_fd;
  int          obs_bad;
  logic        obs_ready0;

  function automatic logic [6:0] seg_tab(input logic [3:0] n);
    logic [6:0] t;
    case (n)
      4'd0: t = 7'h3F; 4'd1: t = 7'h06; 4'd2: t = 7'h5B; 4'd3: t = 7'h4F;
      4'd4: t = 7'h66; 4'd5: t = 7'h6D; 4'd6: t = 7'h7D; 4'd7: t = 7'h07;
      4'd8: t = 7'h7F; 4'd9: t = 7'h6F; default: t = 7'h00;
    endcase
    return t;
  endfunction

  function automatic logic [11:0] pwm_mask(input int b);
    logic [11:0] m;
    for (int s = 0; s < SC; s++) m[s] = ((s % 8) <= b);
    return m;
  endfunction

  function automatic frame_exp_t mk_frame(input logic [15:0] v, input bit lz,
                                          input logic [11:0] m0, input logic [11:0] mr,
                                          input bit fd);
    frame_exp_t e;
    logic zero_above;
    logic [3:0] n;
    zero_above = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      n = v[4*d +: 4];
      zero_above = zero_above && (n == 4'd0);
      e.segs[7*d +: 7]   = (lz && zero_above && d != 0) ? 7'h00 : seg_tab(n);
      e.masks[12*d +: 12] = (d == 0) ? m0 : mr;
    end
    e.fd = fd ? 3'b101 : 3'b000;
    return e;
  endfunction

  // Samples one frame starting at the current negedge (slot 0, timer 0) and ends on
  // the negedge that starts the following frame. Optionally offers a write at c=0.
  task automatic capture_frame(input bit do_wr, input logic [15:0] wdata);
    int fdc;
    logic fd0;
    int d, t;
    fdc = 0; fd0 = 1'b0; obs_bad = 0;
    for (int c = 0; c < FR; c++) begin
      d = c / SD; t = c % SD;
      if (frame_done === 1'b1) begin fdc++; if (c == 0) fd0 = 1'b1; end
      if (t < BC) begin
        if (seg !== 7'h00 || dig_en !== 4'b0000) obs_bad++;
        if (t == 0) obs_mask[d] = 12'h000;
      end else begin
        if (t == BC) obs_seg[d] = seg;
        else if (seg !== obs_seg[d]) obs_bad++;
        if (dig_en === (4'b0001 << d)) obs_mask[d][t-BC] = 1'b1;
        else if (dig_en !== 4'b0000) obs_bad++;
      end
      if (c == 0) begin
        obs_ready0 = wr_ready;
        if (do_wr) begin wr_valid = 1'b1; wr_data = wdata; end
      end
      if (c == 1 && do_wr) wr_valid = 1'b0;
      @(negedge clk);
    end
    obs_fd = {fd0, (fdc > 3) ? 2'd3 : 2'(fdc)};
  endtask

  task automatic sync_frame();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4 * FR && !got; i++) begin
      if (frame_done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    vec++;
    if (!got) begin err++; $display("FAIL sync_frame: frame_done got 0 want 1 within %0d cycles", 4 * FR); end
  endtask

  task automatic test_reset();
    cyc_exp_t e;
    reset = 1'b1; wr_valid = 1'b0; bright = 3'd7; lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if ({seg, dig_en, wr_ready, frame_done} !== {7'h00, 4'b0000, 1'b1, 1'b0}) begin
      err++; $display("FAIL reset_hold: seg/dig_en/rdy/fd got %h/%b/%b/%b want 00/0000/1/0", seg, dig_en, wr_ready, frame_done);
    end
    for (int i = 0; i < SD; i++) cyc_q.push_back((i < BC) ? cyc_exp_t'({7'h00, 4'b0000}) : cyc_exp_t'({7'h3F, 4'b0001}));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < SD; i++) begin
      e = cyc_q.pop_front();
      vec++; if ({seg, dig_en, wr_ready} !== {e.seg, e.dig_en, 1'b1}) begin
        err++; $display("FAIL reset_slot0 cyc%0d: seg/dig_en/rdy got %h/%b/%b want %h/%b/1", i, seg, dig_en, wr_ready, e.seg, e.dig_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write();
    frame_exp_t e;
    vec++; if (wr_ready !== 1'b1) begin err++; $display("FAIL write_ready: got %b want 1", wr_ready); end
    wr_valid = 1'b1; wr_data = 16'h1234;
    @(posedge clk); #1 wr_valid = 1'b0;
    frame_q.push_back(mk_frame(16'h1234, 0, 12'hFFF, 12'hFFF, 1));
    frame_q.push_back(mk_frame(16'h1234, 0, 12'hFFF, 12'hFFF, 1));
    @(negedge clk);
    sync_frame();
    for (int f = 0; f < 2; f++) begin
      capture_frame(0, 16'h0);
      e = frame_q.pop_front();
      for (int d = 0; d < 4; d++) begin
        vec++; if (obs_seg[d] !== e.segs[7*d +: 7]) begin err++; $display("FAIL write f%0d dig%0d seg: got %h want %h", f, d, obs_seg[d], e.segs[7*d +: 7]); end
        vec++; if (obs_mask[d] !== e.masks[12*d +: 12]) begin err++; $display("FAIL write f%0d dig%0d pwm: got %h want %h", f, d, obs_mask[d], e.masks[12*d +: 12]); end
      end
      vec++; if (obs_fd !== e.fd) begin err++; $display("FAIL write f%0d frame_done: got %b want %b", f, obs_fd, e.fd); end
      vec++; if (obs_bad !== 0) begin err++; $display("FAIL write f%0d blank/onehot: got %0d bad cycles want 0", f, obs_bad); end
    end
  endtask

  task automatic test_back_to_back();
    frame_exp_t e;
    int lowcnt;
    logic rdy0, acc_fd;
    bit got;
    lowcnt = 0; got = 1'b0; acc_fd = 1'b0;
    frame_q.push_back(mk_frame(16'h1234, 0, 12'hFFF, 12'hFFF, 1));
    frame_q.push_back(mk_frame(16'h4321, 0, 12'hFFF, 12'hFFF, 1));
    frame_q.push_back(mk_frame(16'h5678, 0, 12'hFFF, 12'hFFF, 1));
    fork
      begin
        rdy0 = wr_ready;
        wr_valid = 1'b1; wr_data = 16'h4321;
        @(posedge clk); #1 wr_data = 16'h5678;
        for (int i = 0; i < 4 * FR && !got; i++) begin
          @(negedge clk);
          if (wr_ready === 1'b1) begin got = 1'b1; acc_fd = frame_done; end
          else lowcnt++;
        end
        @(posedge clk); #1 wr_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 3; f++) begin
          capture_frame(0, 16'h0);
          e = frame_q.pop_front();
          for (int d = 0; d < 4; d++) begin
            vec++; if (obs_seg[d] !== e.segs[7*d +: 7]) begin err++; $display("FAIL b2b f%0d dig%0d seg: got %h want %h", f, d, obs_seg[d], e.segs[7*d +: 7]); end
          end
          vec++; if (obs_fd !== e.fd) begin err++; $display("FAIL b2b f%0d frame_done: got %b want %b", f, obs_fd, e.fd); end
          vec++; if (obs_bad !== 0) begin err++; $display("FAIL b2b f%0d blank/onehot: got %0d bad cycles want 0", f, obs_bad); end
        end
      end
    join
    vec++; if (rdy0 !== 1'b1) begin err++; $display("FAIL b2b first_ready: got %b want 1", rdy0); end
    vec++; if (lowcnt != FR - 1) begin err++; $display("FAIL b2b ready_low: got %0d cycles want %0d", lowcnt, FR - 1); end
    vec++; if (acc_fd !== 1'b1) begin err++; $display("FAIL b2b accept_cycle frame_done: got %b want 1", acc_fd); end
  endtask

  task automatic test_lz();
    frame_exp_t e;
    logic [15:0] vals [3];
    logic [15:0] prev;
    vals[0] = 16'h0050; vals[1] = 16'h0000; vals[2] = 16'h00A0;
    prev = 16'h5678;
    lz_blank = 1'b1;
    for (int k = 0; k < 3; k++) begin
      frame_q.push_back(mk_frame(prev, 1, 12'hFFF, 12'hFFF, 1));
      frame_q.push_back(mk_frame(vals[k], 1, 12'hFFF, 12'hFFF, 1));
      for (int f = 0; f < 2; f++) begin
        capture_frame(f == 0, vals[k]);
        if (f == 0) begin
          vec++; if (obs_ready0 !== 1'b1) begin err++; $display("FAIL lz %h ready: got %b want 1", vals[k], obs_ready0); end
        end
        e = frame_q.pop_front();
        for (int d = 0; d < 4; d++) begin
          vec++; if (obs_seg[d] !== e.segs[7*d +: 7]) begin err++; $display("FAIL lz %h f%0d dig%0d seg: got %h want %h", vals[k], f, d, obs_seg[d], e.segs[7*d +: 7]); end
          vec++; if (obs_mask[d] !== e.masks[12*d +: 12]) begin err++; $display("FAIL lz %h f%0d dig%0d pwm: got %h want %h", vals[k], f, d, obs_mask[d], e.masks[12*d +: 12]); end
        end
      end
      prev = vals[k];
    end
  endtask

  task automatic test_pwm();
    frame_exp_t e;
    lz_blank = 1'b0;
    for (int f = 0; f < 3; f++) begin
      bright = (f == 1) ? 3'd0 : 3'd1;
      case (f)
        0:       frame_q.push_back(mk_frame(16'h00A0, 0, pwm_mask(1), pwm_mask(1), 1));
        1:       frame_q.push_back(mk_frame(16'h00A0, 0, pwm_mask(0), pwm_mask(0), 1));
        default: frame_q.push_back(mk_frame(16'h00A0, 0, pwm_mask(1), pwm_mask(7), 1));
      endcase
      fork
        capture_frame(0, 16'h0);
        if (f == 2) begin
          repeat (BC + 6) @(negedge clk);
          bright = 3'd7;
        end
      join
      e = frame_q.pop_front();
      for (int d = 0; d < 4; d++) begin
        vec++; if (obs_mask[d] !== e.masks[12*d +: 12]) begin err++; $display("FAIL pwm f%0d dig%0d mask: got %h want %h", f, d, obs_mask[d], e.masks[12*d +: 12]); end
        vec++; if (obs_seg[d] !== e.segs[7*d +: 7]) begin err++; $display("FAIL pwm f%0d dig%0d seg: got %h want %h", f, d, obs_seg[d], e.segs[7*d +: 7]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    frame_exp_t e;
    bright = 3'd7;
    wr_valid = 1'b1; wr_data = 16'h9999;
    @(posedge clk); #1 wr_valid = 1'b0;
    repeat (2 * SD + BC + 3) @(negedge clk);
    vec++; if ({dig_en, wr_ready} !== {4'b0100, 1'b0}) begin
      err++; $display("FAIL rst_mid pre: dig_en/rdy got %b/%b want 0100/0", dig_en, wr_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    vec++; if ({seg, dig_en, wr_ready, frame_done} !== {7'h00, 4'b0000, 1'b1, 1'b0}) begin
      err++; $display("FAIL rst_mid post: seg/dig_en/rdy/fd got %h/%b/%b/%b want 00/0000/1/0", seg, dig_en, wr_ready, frame_done);
    end
    frame_q.push_back(mk_frame(16'h0000, 0, 12'hFFF, 12'hFFF, 0));
    frame_q.push_back(mk_frame(16'h0000, 0, 12'hFFF, 12'hFFF, 1));
    for (int f = 0; f < 2; f++) begin
      capture_frame(0, 16'h0);
      e = frame_q.pop_front();
      for (int d = 0; d < 4; d++) begin
        vec++; if (obs_seg[d] !== e.segs[7*d +: 7]) begin err++; $display("FAIL rst_mid f%0d dig%0d seg: got %h want %h", f, d, obs_seg[d], e.segs[7*d +: 7]); end
      end
      vec++; if (obs_fd !== e.fd) begin err++; $display("FAIL rst_mid f%0d frame_done: got %b want %b", f, obs_fd, e.fd); end
      vec++; if (obs_bad !== 0) begin err++; $display("FAIL rst_mid f%0d blank/onehot: got %0d bad cycles want 0", f, obs_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_lz();
    test_pwm();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
